// File: rtl/sram_arbiter_if.sv
// Request/grant bundle between the two SRAM clients and the arbiter.
// The read port (scan-out fetch) and the write port (pixel writer) share it.
interface sram_arbiter_if #(
   parameter int AW = 20
);
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_gnt;
   logic [15:0]   rd_data;
   logic          rd_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic [1:0]    wr_be;
   logic          wr_gnt;
   logic          busy;

   // Arbiter side
   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
      output rd_gnt, rd_data, rd_valid, wr_gnt, busy
   );

   // Client side
   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
      input  rd_gnt, rd_data, rd_valid, wr_gnt, busy
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for the asynchronous 16-bit board SRAM.
// Reads have priority and may stream one per cycle; writes take three cycles
// (WE pulse, data-hold recovery, bus release). A starvation counter forces a
// pending write through after STARVE_LIMIT lost cycles. OE and the DQ driver
// are never active together.
module sram_arbiter #(
   parameter int STARVE_LIMIT = 16,
   parameter int AW           = 20
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   sram_arbiter_if.slave bus,
   output logic [AW-1:0] SRAM_ADDR,
   inout  wire  [15:0]   SRAM_DQ,
   output logic          SRAM_CE_N,
   output logic          SRAM_OE_N,
   output logic          SRAM_WE_N,
   output logic          SRAM_UB_N,
   output logic          SRAM_LB_N
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_WREC  = 2'd3
   } state_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t        r_state;
   state_t        w_state_next;
   logic [7:0]    r_starve_cnt;
   logic          r_drive_en;
   logic [15:0]   r_wr_data;
   logic [15:0]   r_rd_data;
   logic          r_rd_valid;
   logic [AW-1:0] r_addr;
   logic          r_ce_n;
   logic          r_oe_n;
   logic          r_we_n;
   logic          r_ub_n;
   logic          r_lb_n;

   logic          w_force_wr;
   logic          w_rd_gnt;
   logic          w_wr_gnt;
   logic          w_rd_xfer;
   logic          w_wr_xfer;

   // Grant decode: reads win unless a starved write is being forced;
   // writes only start from IDLE so the bus never turns around mid-read.
   always_comb begin
      w_force_wr = bus.wr_req && (r_starve_cnt == LIMIT);
      w_rd_gnt   = 1'b0;
      w_wr_gnt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_rd_gnt = bus.rd_req && !w_force_wr;
            w_wr_gnt = bus.wr_req && !w_rd_gnt;
         end
         S_READ: begin
            w_rd_gnt = bus.rd_req && !w_force_wr;
         end
         default: begin
            w_rd_gnt = 1'b0;
            w_wr_gnt = 1'b0;
         end
      endcase
      w_rd_xfer = bus.rd_req && w_rd_gnt;
      w_wr_xfer = bus.wr_req && w_wr_gnt;
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_rd_xfer)      w_state_next = S_READ;
            else if (w_wr_xfer) w_state_next = S_WRITE;
         end
         S_READ:  w_state_next = w_rd_xfer ? S_READ : S_IDLE;
         S_WRITE: w_state_next = S_WREC;
         S_WREC:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // SRAM pin sequencing and read-data capture.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_addr     <= '0;
         r_wr_data  <= '0;
         r_drive_en <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_ce_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_ub_n     <= 1'b1;
         r_lb_n     <= 1'b1;
      end else begin
         r_ce_n     <= 1'b0;
         r_rd_valid <= (r_state == S_READ);
         if (r_state == S_READ) r_rd_data <= SRAM_DQ;
         case (r_state)
            S_IDLE: begin
               if (w_rd_xfer) begin
                  r_addr <= bus.rd_addr;
                  r_oe_n <= 1'b0;
                  r_ub_n <= 1'b0;
                  r_lb_n <= 1'b0;
               end else if (w_wr_xfer) begin
                  r_addr     <= bus.wr_addr;
                  r_wr_data  <= bus.wr_data;
                  r_ub_n     <= ~bus.wr_be[1];
                  r_lb_n     <= ~bus.wr_be[0];
                  r_drive_en <= 1'b1;
                  r_we_n     <= 1'b0;
               end
            end
            S_READ: begin
               if (w_rd_xfer) begin
                  r_addr <= bus.rd_addr;
               end else begin
                  r_oe_n <= 1'b1;
                  r_ub_n <= 1'b1;
                  r_lb_n <= 1'b1;
               end
            end
            S_WRITE: begin
               // SRAM latches on WE rise; address/data/lanes stay put.
               r_we_n <= 1'b1;
            end
            S_WREC: begin
               r_drive_en <= 1'b0;
               r_ub_n     <= 1'b1;
               r_lb_n     <= 1'b1;
            end
            default: begin
               r_drive_en <= 1'b0;
            end
         endcase
      end
   end

   // Starvation counter: counts consecutive cycles a pending write is refused.
   always_ff @(posedge CLOCK_50) begin
      if (reset)                        r_starve_cnt <= '0;
      else if (!bus.wr_req || w_wr_xfer) r_starve_cnt <= '0;
      else if (r_starve_cnt != LIMIT)    r_starve_cnt <= r_starve_cnt + 8'd1;
   end

   assign bus.rd_gnt   = w_rd_gnt;
   assign bus.wr_gnt   = w_wr_gnt;
   assign bus.rd_data  = r_rd_data;
   assign bus.rd_valid = r_rd_valid;
   assign bus.busy     = (r_state != S_IDLE);

   assign SRAM_ADDR = r_addr;
   assign SRAM_CE_N = r_ce_n;
   assign SRAM_OE_N = r_oe_n;
   assign SRAM_WE_N = r_we_n;
   assign SRAM_UB_N = r_ub_n;
   assign SRAM_LB_N = r_lb_n;
   assign SRAM_DQ   = r_drive_en ? r_wr_data : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
module tb_sram_arbiter;
   localparam int AW = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] sram_addr;
   wire  [15:0]   sram_dq;
   logic          ce_n, oe_n, we_n, ub_n, lb_n;

   int n_checks = 0;
   int n_fail   = 0;
   int contention = 0;
   int we_bad = 0;
   int we_run = 0;

   logic [15:0] mem [0:1023];

   sram_arbiter_if #(.AW(AW)) bus ();

   sram_arbiter #(.STARVE_LIMIT(16), .AW(AW)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus),
      .SRAM_ADDR(sram_addr),
      .SRAM_DQ  (sram_dq),
      .SRAM_CE_N(ce_n),
      .SRAM_OE_N(oe_n),
      .SRAM_WE_N(we_n),
      .SRAM_UB_N(ub_n),
      .SRAM_LB_N(lb_n)
   );

   always #10 clk = ~clk;

   // Async SRAM model: drives DQ while reading, captures byte lanes while WE low.
   assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (!ce_n && !we_n) begin
         if (!ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
         if (!lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
      end
   end

   // Bus-contention and WE-pulse-width monitors.
   always @(negedge clk) begin
      if (!oe_n && dut.r_drive_en) contention <= contention + 1;
      if (!we_n && we_run >= 1) we_bad <= we_bad + 1;
      we_run <= !we_n ? we_run + 1 : 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Returns at #1 after the write transfer edge.
   task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
      bit got = 0;
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.wr_be   = be;
      bus.wr_req  = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (bus.wr_gnt) got = 1;
         tick();
      end
      bus.wr_req = 1'b0;
      if (!got) chk("wr_grant_timeout", 0, 1);
   endtask

   // Called at #1 after a read transfer edge (read issued from IDLE, rd_req dropped).
   task automatic finish_read(input logic [15:0] exp, input string tag);
      chk({tag, "_valid_early"}, bus.rd_valid, 1'b0);
      tick();
      chk({tag, "_valid"}, bus.rd_valid, 1'b1);
      chk({tag, "_data"}, bus.rd_data, exp);
      tick();
      chk({tag, "_valid_drop"}, bus.rd_valid, 1'b0);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [15:0] exp, input string tag);
      bit got = 0;
      bus.rd_addr = a;
      bus.rd_req  = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (bus.rd_gnt) got = 1;
         tick();
      end
      bus.rd_req = 1'b0;
      if (!got) chk({tag, "_grant_timeout"}, 0, 1);
      else finish_read(exp, tag);
   endtask

   initial begin
      bit got;
      int waits, losses, drains, g, n, gaps, last;
      logic we_after, de_after, gnt;

      reset = 1'b1;
      bus.rd_req = 0; bus.rd_addr = '0;
      bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = 2'b00;
      tick(); tick();

      // Reset state
      chk("rst_ce_n", ce_n, 1'b1);
      chk("rst_oe_n", oe_n, 1'b1);
      chk("rst_we_n", we_n, 1'b1);
      chk("rst_ublb_n", {ub_n, lb_n}, 2'b11);
      chk("rst_addr", sram_addr, 20'h0);
      chk("rst_rd_valid", bus.rd_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      reset = 1'b0;
      tick();
      chk("run_ce_n", ce_n, 1'b0);

      // Single write then read
      do_write(20'h00012, 16'h15D7, 2'b11);
      chk("wr1_we_low", we_n, 1'b0);
      chk("wr1_busy", bus.busy, 1'b1);
      chk("wr1_dq", sram_dq, 16'h15D7);
      bus.rd_addr = 20'h00012;
      bus.rd_req  = 1'b1;
      waits = 0; got = 0; we_after = 0; de_after = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.rd_gnt) got = 1; else waits++;
         tick();
         if (i == 0) begin
            we_after = we_n;
            de_after = dut.r_drive_en;
         end
      end
      bus.rd_req = 1'b0;
      chk("wr1_we_rise", we_after, 1'b1);
      chk("wr1_data_hold", de_after, 1'b1);
      chk("wr1_rd_turnaround_wait", waits, 2);
      finish_read(16'h15D7, "rd1");

      // Byte enables
      do_write(20'h00040, 16'hFFFF, 2'b11);
      do_write(20'h00040, 16'h1200, 2'b10);
      do_read(20'h00040, 16'h12FF, "be_rd");
      do_write(20'h00040, 16'h0000, 2'b00);
      do_read(20'h00040, 16'h12FF, "be00_rd");

      // Back-to-back reads over preloaded words
      for (int k = 0; k < 8; k++) do_write(AW'(k), 16'hA000 + 16'(k), 2'b11);
      bus.rd_addr = '0;
      bus.rd_req  = 1'b1;
      g = 0; n = 0; gaps = 0; last = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         gnt = bus.rd_gnt && bus.rd_req;
         tick();
         if (gnt) begin
            g++;
            if (g == 8) bus.rd_req = 1'b0;
            else bus.rd_addr = AW'(g);
         end
         if (bus.rd_valid) begin
            chk($sformatf("b2b_data%0d", n), bus.rd_data, 16'hA000 + 16'(n));
            if (n > 0 && c != last + 1) gaps++;
            last = c;
            n++;
         end
      end
      bus.rd_req = 1'b0;
      chk("b2b_count", n, 8);
      chk("b2b_gaps", gaps, 0);

      // Simultaneous requests in IDLE, then starvation
      bus.rd_addr = '0;
      bus.rd_req  = 1'b1;
      bus.wr_addr = 20'h00100;
      bus.wr_data = 16'hBEEF;
      bus.wr_be   = 2'b11;
      bus.wr_req  = 1'b1;
      @(negedge clk);
      chk("sim_rd_gnt", bus.rd_gnt, 1'b1);
      chk("sim_wr_gnt", bus.wr_gnt, 1'b0);
      tick();
      chk("sim_starve_cnt", dut.r_starve_cnt, 8'd1);
      losses = 1; drains = 0; got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (bus.wr_gnt) got = 1;
         else begin
            losses++;
            if (!bus.rd_gnt) drains++;
         end
         tick();
      end
      bus.wr_req = 1'b0;
      // 16 losses while the counter climbs, plus the READ drain cycle.
      chk("starve_losses", losses, 17);
      chk("starve_drain_cycles", drains, 1);
      waits = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.rd_gnt) got = 1; else waits++;
         tick();
      end
      chk("starve_rd_resume_wait", waits, 2);
      bus.rd_req = 1'b0;
      tick(); tick();
      chk("starve_wr_mem", mem[10'h100], 16'hBEEF);

      // Reset in the middle of a write
      do_write(20'h00200, 16'h5555, 2'b11);
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("mid_rst_we_n", we_n, 1'b1);
      chk("mid_rst_oe_n", oe_n, 1'b1);
      chk("mid_rst_drive", dut.r_drive_en, 1'b0);
      chk("mid_rst_busy", bus.busy, 1'b0);
      tick();
      chk("post_rst_ce_n", ce_n, 1'b0);
      chk("post_rst_rd_valid", bus.rd_valid, 1'b0);
      chk("post_rst_busy", bus.busy, 1'b0);

      chk("no_contention", contention, 0);
      chk("we_one_cycle", we_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
